rom_bus_if: RTL

//  68000 bus slave in front of the synchronous program ROM. Decodes the CPU address window and drives the ROM address.

---
 rtl/rom_bus_if_pkg.sv | 16 +
 rtl/rom_bus_if_dtack_timer.sv | 26 ++
 rtl/rom_bus_if.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rom_bus_if_pkg.sv
// Shared types and helpers for the CPU-bus ROM slave and future RAM/IO slaves.
package rom_bus_pkg;

  localparam int unsigned CNT_WIDTH = 5;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // addr carries A[23:1]; compare the bits above the window against the base.
  function automatic logic window_hit(input logic [22:0] addr, input logic [23:0] base,
                                      input int unsigned aw);
    logic [23:0] byte_addr;
    byte_addr = {addr, 1'b0};
    return (byte_addr >> (aw + 1)) == (base >> (aw + 1));
  endfunction

endpackage

// File: rtl/rom_bus_if_dtack_timer.sv
// Loadable down-counter that flags zero; paces DTACK for bus slaves.
module dtack_timer
  import rom_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rom_bus_if.sv
// 68000 bus slave for the synchronous program ROM.
// Build option ROM_WRITE_BERR_EN: writes into the window answer with BERR instead of DTACK.
module rom_bus_if
  import rom_bus_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter logic [23:0] BASE_ADDR     = 24'h0,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WAIT_STATES   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [22:0]              cpu_addr,
  input  logic                     cpu_as_n,
  input  logic                     cpu_uds_n,
  input  logic                     cpu_lds_n,
  input  logic                     cpu_rw,
  output logic [DATA_WIDTH-1:0]    cpu_din,
  output logic                     cpu_oe,
  output logic                     cpu_dtack_n,
  output logic                     cpu_berr_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout
);

  localparam logic [CNT_WIDTH-1:0] LOAD_VALUE = CNT_WIDTH'(READ_LATENCY + WAIT_STATES);

  state_t                   state, state_next;
  logic                     rw_q, rw_next;
  logic                     armed, armed_next;
  logic                     hit, start, load, cnt_zero;
  logic                     dtack_n_next, berr_n_next, oe_next;
  logic [DATA_WIDTH-1:0]    din_next;
  logic [ADDRESS_WIDTH-1:0] rom_addr_next;

  assign hit = window_hit(cpu_addr, BASE_ADDR, ADDRESS_WIDTH);

  // armed: AS has been seen high since the last start or reset, so a strobe
  // still held low across a reset cannot launch a new cycle.
  assign start = armed & !cpu_as_n & hit & (!cpu_uds_n | !cpu_lds_n);

  dtack_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (LOAD_VALUE),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_next    = state;
    rw_next       = rw_q;
    armed_next    = armed | cpu_as_n;
    load          = 1'b0;
    dtack_n_next  = cpu_dtack_n;
    berr_n_next   = cpu_berr_n;
    oe_next       = cpu_oe;
    din_next      = cpu_din;
    rom_addr_next = rom_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = WAIT;
          rom_addr_next = cpu_addr[ADDRESS_WIDTH-1:0];
          rw_next       = cpu_rw;
          load          = 1'b1;
          armed_next    = 1'b0;
        end
      end
      WAIT: begin
        if (cpu_as_n) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = ACK;
          if (rw_q) begin
            din_next     = rom_dout;
            oe_next      = 1'b1;
            dtack_n_next = 1'b0;
          end else begin
`ifdef ROM_WRITE_BERR_EN
            berr_n_next  = 1'b0;
`else
            dtack_n_next = 1'b0;
`endif
          end
        end
      end
      ACK: begin
        if (cpu_as_n) begin
          state_next   = IDLE;
          dtack_n_next = 1'b1;
          berr_n_next  = 1'b1;
          oe_next      = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rw_q        <= 1'b1;
      armed       <= 1'b0;
      cpu_dtack_n <= 1'b1;
      cpu_berr_n  <= 1'b1;
      cpu_oe      <= 1'b0;
      cpu_din     <= '0;
      rom_addr    <= '0;
    end else begin
      state       <= state_next;
      rw_q        <= rw_next;
      armed       <= armed_next;
      cpu_dtack_n <= dtack_n_next;
      cpu_berr_n  <= berr_n_next;
      cpu_oe      <= oe_next;
      cpu_din     <= din_next;
      rom_addr    <= rom_addr_next;
    end
  end

endmodule
